axil_ram_slave: RTL
===================

# axil_ram_slave

AXI4-Lite responder that backs the CPU's memory port with on-chip word RAM. It sits on the far side of the AXI master wrapper: it accepts the load and store transactions the core issues through its unified memory controller, and it returns read data and write responses. SB/SH/SW width arrives already encoded as WSTRB. Read and write channels run independent state machines and share one RAM bank.

## Interface
Parameters:
- ADDR_W, 32: AXI address width.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.

Ports:
- clk  in  1  single clock; all logic posedge.
- reset  in  1  asynchronous, active-high reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid / s_awready  in / out  1  write-address handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte-lane enables.
- s_wvalid / s_wready  in / out  1  write-data handshake.
- s_bresp  out  2  write response.
- s_bvalid / s_bready  out / in  1  write-response handshake.
- s_araddr  in  ADDR_W  read address.
- s_arvalid / s_arready  in / out  1  read-address handshake.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response.
- s_rvalid / s_rready  out / in  1  read-data handshake.

## Operation
- Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored; lane selection comes only from WSTRB.
- In range: (addr - BASE_ADDR) < 4*DEPTH_WORDS, unsigned compare. Out of range gives SLVERR (2'b10); in range gives OKAY (2'b00).
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: s_awready = !aw_held and s_wready = !w_held.
  - Each handshake latches its payload and sets its held flag.
  - AW and W may complete in either order, or in the same cycle.
  - On the edge where both are held or completing, the FSM moves to W_RESP.
  - On that same edge the RAM is written, but only the lanes with WSTRB[i]=1 and only if in range. Out-of-range writes leave the RAM untouched.
  - W_RESP: s_bvalid=1 and s_bresp is held stable until s_bready. On that handshake the FSM returns to W_IDLE and clears both held flags.
- Read FSM states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE: s_arready=1. An AR handshake latches the address and moves to R_FETCH.
  - R_FETCH: the RAM is read synchronously, then the FSM moves to R_DATA.
  - R_DATA: s_rvalid=1, with s_rdata/s_rresp held stable until s_rready. Then the FSM returns to R_IDLE.
  - An out-of-range read returns s_rdata=0 with SLVERR.
- Read/write collision (RAM write and RAM read to the same word on the same edge): the read returns the old data (read-first).
- RAM contents are not cleared by reset.

## Timing
- Reset values: all *ready=0, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0; FSMs in W_IDLE/R_IDLE; held flags clear.
- Readies are registered. They rise on the first clk edge with reset low.
- Write latency: s_bvalid rises on the edge after the later of the AW/W handshakes.
  - The RAM is updated on that same edge.
  - Minimum write period is 2 cycles with s_bready tied high.
- Read latency: s_rvalid rises on the 2nd edge after the AR-handshake edge.
  - Minimum read period is 3 cycles with s_rready tied high.
- No ready is asserted while the corresponding response is pending. There is at most one outstanding transaction per direction.
- Reset asserted mid-transaction: all valids and readies drop immediately and latched requests are discarded.
  - A write whose RAM-update edge has not yet occurred is lost.
  - No response is issued after reset for that write.
- Output valids never depend combinationally on inputs.

## Structure
- Package axil_pkg holds:
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Typedefs wstate_t {W_IDLE, W_RESP} and rstate_t {R_IDLE, R_FETCH, R_DATA}.
- Sub-module axil_ram_bank: DEPTH_WORDS x 32 synchronous RAM.
  - Write port: we, 4-bit byte enable, word address, data.
  - Read port: registered word address, read-first.
- Top level contains the two FSMs, the address decode and the response registers.

## Test plan
- Full-word write: AW 0x10 and W 0xDEADBEEF/4'hF issued in the same cycle, then a read of 0x10.
  - Required: bvalid one cycle later with OKAY.
  - Required: rdata=0xDEADBEEF with OKAY, rvalid 2 edges after AR.
- Byte and half-word strobes: write 0x11223344 to 0x20, then 0xAAxx_xxxx with strobe 4'h8, then 0x0000BBCC with strobe 4'h3.
  - Required: a read of 0x20 returns 0xAA22BBCC.
- Decoupled channels: AW 0x30 asserted 3 cycles before W 0x55.
  - Required: awready drops after the AW handshake.
  - Required: bvalid appears one edge after the W handshake, and word 0x30 reads back 0x55.
- Out of range: with DEPTH_WORDS=1024, write and read at 0x1000.
  - Required: bresp=SLVERR and rresp=SLVERR with rdata=0.
  - Required: word 0 is unchanged.
- Backpressure: hold s_rready=0 for 5 cycles and s_bready=0 for 4 cycles.
  - Required: rvalid/rdata and bvalid/bresp stay stable.
  - Required: arready and awready stay 0 until the respective handshake.
- Reset mid-operation: assert reset while in R_FETCH and while AW is held without W.
  - Required: all outputs reach reset values asynchronously.
  - Required: after release, no stale rvalid or bvalid, and previously written RAM data is retained.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants, state encodings and helpers for the RAM responder.
package axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_FETCH = 2'b01,
    R_DATA  = 2'b10
  } rstate_t;

  // Map an address-decode hit onto the AXI response code.
  function automatic logic [1:0] resp_of(input logic hit);
    return hit ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axil_ram_bank.sv
// Single-bank word RAM: byte-enabled write port, registered read-first read port.
module axil_ram_bank
  import axil_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [STRB_W-1:0] be_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Lane-masked write and read-first registered read on the same edge.
  // NOTE: the array and its output register have no reset; contents survive a
  // bus reset and a reset here would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (be_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite responder backed by on-chip word RAM; independent read/write FSMs.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
);

  localparam int unsigned       IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   SPAN  = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  // Write-side state
  wstate_t           wstate_q, wstate_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  // Read-side state
  rstate_t           rstate_q, rstate_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;

  // Handshakes and effective write payload (registered copy or same-cycle bypass)
  logic              aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0] waddr_eff, w_off, r_off;
  logic [DATA_W-1:0] wdata_eff;
  logic [STRB_W-1:0] wstrb_eff;
  logic              w_hit, r_hit;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign aw_hs = s_awvalid && awready_q;
  assign w_hs  = s_wvalid && wready_q;
  assign ar_hs = s_arvalid && arready_q;

  assign waddr_eff = aw_hs ? s_awaddr : awaddr_q;
  assign wdata_eff = w_hs ? s_wdata : wdata_q;
  assign wstrb_eff = w_hs ? s_wstrb : wstrb_q;

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR decode as out of range.
  assign w_off = waddr_eff - BASE_ADDR;
  assign r_off = araddr_q - BASE_ADDR;
  assign w_hit = ({1'b0, w_off} < SPAN);
  assign r_hit = ({1'b0, r_off} < SPAN);

  // Write FSM: collect AW and W in any order, commit to RAM, then hold B.
  // NOTE: every variable assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          wstate_d = W_RESP;
          bvalid_d = 1'b1;
          bresp_d  = resp_of(w_hit);
          ram_we   = w_hit;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    // Readies look at next state so they are registered yet never open while a response is pending.
    awready_d = (wstate_d == W_IDLE) && !aw_held_d;
    wready_d  = (wstate_d == W_IDLE) && !w_held_d;
  end

  // Read FSM: accept AR, spend one cycle in the RAM, then hold R.
  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    ram_re   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d = s_araddr;
          rstate_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re   = 1'b1;
        rstate_d = R_DATA;
        rvalid_d = 1'b1;
        rresp_d  = resp_of(r_hit);
      end
      R_DATA: begin
        if (s_rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        rstate_d = R_IDLE;
        rvalid_d = 1'b0;
      end
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Write-side registers; reset drops readies/valids and discards latched requests.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // its _d value from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      araddr_q  <= araddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  axil_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (wstrb_eff),
    .waddr_i (w_off[IDX_W+1:2]),
    .wdata_i (wdata_eff),
    .re_i    (ram_re),
    .raddr_i (r_off[IDX_W+1:2]),
    .rdata_o (ram_rdata)
  );

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  // Out-of-range reads and idle cycles present zero data.
  assign s_rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_rdata : '0;

endmodule
